countdown_sequencer: RTL and testbench

Generates the 3‑2‑1 race-start countdown that drives the on-screen number sprite. Launched by the game controller when it enters COUNTDOWN, it steps a 2-bit digit down once per second and emits a single-cycle `done` pulse that the controller uses to move to RACING. `num` connects directly to the number sprite's `num` input. `num` = 0 means "draw nothing".

---
 rtl/game_pkg.sv | 15 +
 rtl/countdown_sequencer_tick_gen.sv | 38 +++
 rtl/countdown_sequencer.sv | 135 +++++++++++++
 tb/tb_countdown_sequencer.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared game constants: top-level game-state codes and timing defaults.
package game_pkg;

    typedef enum logic [2:0] {
        GS_IDLE      = 3'd0,
        GS_SETTING   = 3'd1,
        GS_COUNTDOWN = 3'd3,
        GS_RACING    = 3'd4,
        GS_PAUSE     = 3'd5,
        GS_FINISH    = 3'd6
    } game_state_e;

    localparam int TICKS_PER_SEC_DEF = 100_000_000;

endpackage

// File: rtl/countdown_sequencer_tick_gen.sv
// Seconds prescaler: one-cycle sec_tick_o when the count reaches TICKS_PER_SEC-1.
module tick_gen
    import game_pkg::*;
#(
    parameter int TICKS_PER_SEC = TICKS_PER_SEC_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    input  logic clr_i,
    output logic sec_tick_o
);

    localparam int CW = $clog2(TICKS_PER_SEC);
    localparam logic [CW-1:0] LAST = CW'(TICKS_PER_SEC - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign sec_tick_o = en_i && !clr_i && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/countdown_sequencer.sv
// Race-start countdown (START_NUM..1 then done pulse) for the number sprite.
// Define COUNTDOWN_BEEP_EN to enable the per-digit beep and the GO tone.
module countdown_sequencer
    import game_pkg::*;
#(
    parameter int TICKS_PER_SEC = TICKS_PER_SEC_DEF,
    parameter int START_NUM     = 3,
    parameter int BEEP_TICKS    = 10_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       hold,
    input  logic       abort,
    output logic [1:0] num,
    output logic       active,
    output logic       done,
    output logic       beep
);

    if (START_NUM < 1 || START_NUM > 3) begin : g_bad_start
        $error("countdown_sequencer: START_NUM must be 1..3");
    end
    if (TICKS_PER_SEC < 2) begin : g_bad_ticks
        $error("countdown_sequencer: TICKS_PER_SEC must be >= 2");
    end
    if (BEEP_TICKS < 1 || BEEP_TICKS >= TICKS_PER_SEC) begin : g_bad_beep
        $error("countdown_sequencer: BEEP_TICKS must be 1..TICKS_PER_SEC-1");
    end

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_COUNT = 1'b1
    } state_e;

    state_e     state_q;
    logic [1:0] num_q;
    logic       active_q;
    logic       done_q;
    logic       sec_tick;
    logic       launch;
    logic       expire;

    assign launch = (state_q == S_IDLE) && start && !abort;
    assign expire = (state_q == S_COUNT) && !abort && sec_tick;

    tick_gen #(
        .TICKS_PER_SEC(TICKS_PER_SEC)
    ) u_tick (
        .clk       (clk),
        .rst_n     (rst_n),
        .en_i      ((state_q == S_COUNT) && !hold),
        .clr_i     ((state_q == S_IDLE) || abort),
        .sec_tick_o(sec_tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            num_q    <= 2'd0;
            active_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (launch) begin
                        state_q  <= S_COUNT;
                        num_q    <= 2'(START_NUM);
                        active_q <= 1'b1;
                    end
                end
                S_COUNT: begin
                    if (abort) begin
                        state_q  <= S_IDLE;
                        num_q    <= 2'd0;
                        active_q <= 1'b0;
                    end else if (expire) begin
                        if (num_q > 2'd1) begin
                            num_q <= num_q - 2'd1;
                        end else begin
                            state_q  <= S_IDLE;
                            num_q    <= 2'd0;
                            active_q <= 1'b0;
                            done_q   <= 1'b1;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign num    = num_q;
    assign active = active_q;
    assign done   = done_q;

`ifdef COUNTDOWN_BEEP_EN
    localparam int BW = $clog2(2 * BEEP_TICKS + 1);

    logic [BW-1:0] bcnt_q, bcnt_d;
    logic          digit_evt;
    logic          go_evt;

    assign digit_evt = launch || (expire && num_q > 2'd1);
    assign go_evt    = expire && (num_q == 2'd1);

    // Abort beats everything; a new tone restarts the count even mid-beep.
    always_comb begin
        bcnt_d = bcnt_q;
        if (abort) begin
            bcnt_d = '0;
        end else if (go_evt) begin
            bcnt_d = BW'(2 * BEEP_TICKS);
        end else if (digit_evt) begin
            bcnt_d = BW'(BEEP_TICKS);
        end else if (!hold && bcnt_q != '0) begin
            bcnt_d = bcnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcnt_q <= '0;
        end else begin
            bcnt_q <= bcnt_d;
        end
    end

    assign beep = (bcnt_q != '0) && !hold;
`else
    assign beep = 1'b0;
`endif

endmodule

// File: tb/tb_countdown_sequencer.sv
// Directed + random bench for countdown_sequencer (START_NUM 3 and 1 instances).
module tb_countdown_sequencer;

    localparam int T = 10;
    localparam int B = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       hold = 1'b0;
    logic       abort = 1'b0;
    logic [1:0] num0, num1;
    logic       act0, act1, done0, done1, beep0, beep1;

    int checks = 0;
    int errors = 0;

    // Reference: remaining countdown cycles; shown digit = ceil(rem / T).
    int rem[2];
    bit mact[2];
    bit mdone[2];
    int brem[2];

    always #5 clk = ~clk;

    countdown_sequencer #(.TICKS_PER_SEC(T), .START_NUM(3), .BEEP_TICKS(B)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start), .hold(hold), .abort(abort),
        .num(num0), .active(act0), .done(done0), .beep(beep0)
    );

    countdown_sequencer #(.TICKS_PER_SEC(T), .START_NUM(1), .BEEP_TICKS(B)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start), .hold(hold), .abort(abort),
        .num(num1), .active(act1), .done(done1), .beep(beep1)
    );

    function automatic int sn(input int i);
        return (i == 0) ? 3 : 1;
    endfunction

    function automatic int mnum(input int i);
        return mact[i] ? (rem[i] + T - 1) / T : 0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            rem[i] = 0; mact[i] = 0; mdone[i] = 0; brem[i] = 0;
        end
    endtask

    task automatic model_edge(input int i);
        int prev;
        prev = mnum(i);
        mdone[i] = 0;
        if (!mact[i]) begin
            if (start && !abort) begin
                mact[i] = 1;
                rem[i] = sn(i) * T;
            end
        end else if (abort) begin
            mact[i] = 0;
            rem[i] = 0;
        end else if (!hold) begin
            rem[i]--;
            if (rem[i] == 0) begin
                mact[i] = 0;
                mdone[i] = 1;
            end
        end
        if (abort) brem[i] = 0;
        else if (mdone[i]) brem[i] = 2 * B;
        else if (mnum(i) != 0 && mnum(i) != prev) brem[i] = B;
        else if (!hold && brem[i] > 0) brem[i]--;
    endtask

    function automatic bit exp_beep(input int i);
`ifdef COUNTDOWN_BEEP_EN
        return (brem[i] > 0) && !hold;
`else
        return 1'b0;
`endif
    endfunction

    task automatic check_all();
        chk("num0", 32'(num0), 32'(mnum(0)));
        chk("act0", 32'(act0), 32'(mact[0]));
        chk("done0", 32'(done0), 32'(mdone[0]));
        chk("beep0", 32'(beep0), 32'(exp_beep(0)));
        chk("num1", 32'(num1), 32'(mnum(1)));
        chk("act1", 32'(act1), 32'(mact[1]));
        chk("done1", 32'(done1), 32'(mdone[1]));
        chk("beep1", 32'(beep1), 32'(exp_beep(1)));
    endtask

    task automatic step(input bit s, input bit h, input bit a);
        @(negedge clk);
        start = s; hold = h; abort = a;
        @(posedge clk);
        model_edge(0);
        model_edge(1);
        #1;
        check_all();
    endtask

    task automatic run(input int limit, input int h_from, input int h_to,
                       input int s_at, input int a_at,
                       output int t2, output int td0, output int td1);
        t2 = -1; td0 = -1; td1 = -1;
        for (int n = 1; n <= limit; n++) begin
            step(n == s_at, n >= h_from && n <= h_to, n == a_at);
            if (t2 < 0 && num0 == 2'd2) t2 = n;
            if (td1 < 0 && done1) td1 = n;
            if (done0) begin
                td0 = n;
                break;
            end
        end
    endtask

    initial begin
        int t2, td0, td1;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_num0", 32'(num0), 0);
        chk("rst_act0", 32'(act0), 0);
        chk("rst_done0", 32'(done0), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Plain countdown
        repeat (4) step(0, 0, 0);
        step(1, 0, 0);
        chk("first_digit", 32'(num0), 3);
        run(60, 0, -1, 0, 0, t2, td0, td1);
        chk("t_num2", 32'(t2), 10);
        chk("t_done", 32'(td0), 30);
        chk("t_done_s1", 32'(td1), 10);
        step(0, 0, 0);

        // Hold extends the current digit by the held cycles
        step(1, 0, 0);
        run(60, 5, 9, 0, 0, t2, td0, td1);
        chk("h_num2", 32'(t2), 15);
        chk("h_done", 32'(td0), 35);
        step(0, 0, 0);

        // Abort mid-count: no done, then a clean restart from 3
        step(1, 0, 0);
        run(40, 0, -1, 0, 15, t2, td0, td1);
        chk("a_nodone", 32'(td0), 32'hFFFF_FFFF);
        chk("a_idle", 32'(act0), 0);
        step(1, 0, 0);
        chk("a_restart", 32'(num0), 3);
        run(40, 0, -1, 0, 0, t2, td0, td1);
        chk("a_rdone", 32'(td0), 30);

        // start+abort in idle stays idle; re-start during count is ignored
        step(1, 0, 1);
        chk("sa_idle", 32'(act0), 0);
        step(1, 0, 0);
        run(60, 0, -1, 7, 0, t2, td0, td1);
        chk("rs_done", 32'(td0), 30);

        // start held through done relaunches on the next cycle
        step(1, 0, 0);
        for (int n = 0; n < 30; n++) step(1, 0, 0);
        chk("relaunch_done", 32'(done0), 1);
        step(1, 0, 0);
        chk("relaunch_num", 32'(num0), 3);

        // Asynchronous reset mid-count
        repeat (7) step(0, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_num0", 32'(num0), 0);
        chk("ar_act0", 32'(act0), 0);
        chk("ar_done0", 32'(done0), 0);
        chk("ar_beep0", 32'(beep0), 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // Random traffic against the reference
        for (int n = 0; n < 3000; n++) begin
            step(($urandom % 4) == 0, ($urandom % 5) == 0, ($urandom % 40) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
